// File: rtl/stereo_core_sequencer.sv
// Time-shares one mono reverb core between the left and right channels of a stereo stream.
// Pairs the two input samples, sends them left then right, and returns the results as a stereo pair.
module stereo_core_sequencer #(
  parameter int DATA_W   = 24,
  parameter int DAMP_W   = 25,
  parameter int DECAY_W  = 25,
  parameter int MIX_W    = 24,
  parameter int PDLY_W   = 10,
  parameter int SKEW_MAX = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  left_in_data,
  input  logic               left_in_valid,
  output logic               left_in_ready,
  input  logic [DATA_W-1:0]  right_in_data,
  input  logic               right_in_valid,
  output logic               right_in_ready,
  output logic [DATA_W-1:0]  core_in_data,
  output logic               core_in_chan,
  output logic               core_in_valid,
  input  logic               core_in_ready,
  input  logic [DATA_W-1:0]  core_out_data,
  input  logic               core_out_valid,
  output logic               core_out_ready,
  output logic [DATA_W-1:0]  left_out_data,
  output logic               left_out_valid,
  input  logic               left_out_ready,
  output logic [DATA_W-1:0]  right_out_data,
  output logic               right_out_valid,
  input  logic               right_out_ready,
  input  logic [DAMP_W-1:0]  damping_in,
  input  logic [DECAY_W-1:0] decay_in,
  input  logic [MIX_W-1:0]   mix_in,
  input  logic [PDLY_W-1:0]  predelay_in,
  output logic [DAMP_W-1:0]  damping_q,
  output logic [DECAY_W-1:0] decay_q,
  output logic [MIX_W-1:0]   mix_q,
  output logic [PDLY_W-1:0]  predelay_q,
  output logic [15:0]        frame_count,
  output logic               pair_error,
  output logic [2:0]         state_dbg
);

  // Every handshake is valid/ready: a transfer happens on a rising clk edge where both are high;
  // a source holds valid and data stable until that edge.

  localparam int SKEW_W = $clog2(SKEW_MAX + 1);

  typedef enum logic [2:0] {
    CAPTURE = 3'd0,
    SEND_L  = 3'd1,
    RECV_L  = 3'd2,
    SEND_R  = 3'd3,
    RECV_R  = 3'd4,
    OUTPUT  = 3'd5
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   hold_l, hold_r, res_l, res_r;
  logic                held_l, held_r, done_l, done_r;
  logic [SKEW_W-1:0]   skew_cnt;
  logic                in_cap, acc_l, acc_r, have_l, have_r, pair_ready;
  logic                lone, timeout, hs_lo, hs_ro, out_done;

  always_comb begin
    in_cap         = (state == CAPTURE);
    left_in_ready  = !reset && in_cap && !held_l;
    right_in_ready = !reset && in_cap && !held_r;
    acc_l          = left_in_valid && left_in_ready;
    acc_r          = right_in_valid && right_in_ready;
    have_l         = held_l || acc_l;
    have_r         = held_r || acc_r;
    pair_ready     = in_cap && have_l && have_r;
    lone           = held_l ^ held_r;
    // A lone sample is dropped on the edge its wait reaches SKEW_MAX, unless its partner arrives then.
    timeout        = in_cap && lone && !pair_ready && (skew_cnt == SKEW_W'(SKEW_MAX - 1));

    core_in_valid  = (state == SEND_L) || (state == SEND_R);
    core_in_chan   = (state == SEND_R);
    core_in_data   = (state == SEND_L) ? hold_l : (state == SEND_R) ? hold_r : '0;
    core_out_ready = (state == RECV_L) || (state == RECV_R);

    left_out_valid  = (state == OUTPUT) && !done_l;
    right_out_valid = (state == OUTPUT) && !done_r;
    left_out_data   = res_l;
    right_out_data  = res_r;
    hs_lo           = left_out_valid && left_out_ready;
    hs_ro           = right_out_valid && right_out_ready;
    out_done        = (done_l || hs_lo) && (done_r || hs_ro);
    state_dbg       = state;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CAPTURE: if (pair_ready)     state_nxt = SEND_L;
      SEND_L:  if (core_in_ready)  state_nxt = RECV_L;
      RECV_L:  if (core_out_valid) state_nxt = SEND_R;
      SEND_R:  if (core_in_ready)  state_nxt = RECV_R;
      RECV_R:  if (core_out_valid) state_nxt = OUTPUT;
      OUTPUT:  if (out_done)       state_nxt = CAPTURE;
      default:                     state_nxt = CAPTURE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CAPTURE;
      hold_l      <= '0;
      hold_r      <= '0;
      held_l      <= 1'b0;
      held_r      <= 1'b0;
      res_l       <= '0;
      res_r       <= '0;
      done_l      <= 1'b0;
      done_r      <= 1'b0;
      skew_cnt    <= '0;
      pair_error  <= 1'b0;
      frame_count <= '0;
      damping_q   <= '0;
      decay_q     <= '0;
      mix_q       <= '0;
      predelay_q  <= '0;
    end else begin
      state      <= state_nxt;
      pair_error <= timeout;

      if (acc_l) begin
        hold_l <= left_in_data;
        held_l <= 1'b1;
      end else if (timeout && held_l) begin
        held_l <= 1'b0;
      end
      if (acc_r) begin
        hold_r <= right_in_data;
        held_r <= 1'b1;
      end else if (timeout && held_r) begin
        held_r <= 1'b0;
      end

      if (in_cap && lone && !pair_ready && !timeout)
        skew_cnt <= skew_cnt + SKEW_W'(1);
      else
        skew_cnt <= '0;

      // Parameters are frozen only on the capture edge so the core sees one set per frame.
      if (pair_ready) begin
        damping_q  <= damping_in;
        decay_q    <= decay_in;
        mix_q      <= mix_in;
        predelay_q <= predelay_in;
      end

      if (state == RECV_L && core_out_valid) res_l <= core_out_data;
      if (state == RECV_R && core_out_valid) begin
        res_r  <= core_out_data;
        held_l <= 1'b0;
        held_r <= 1'b0;
      end

      if (state == OUTPUT) begin
        if (out_done) begin
          done_l      <= 1'b0;
          done_r      <= 1'b0;
          frame_count <= frame_count + 16'd1;
        end else begin
          done_l <= done_l || hs_lo;
          done_r <= done_r || hs_ro;
        end
      end
    end
  end

endmodule

// File: tb/tb_stereo_core_sequencer.sv
// Directed bench for stereo_core_sequencer: table-driven frames plus hand-written corner sequences.
module tb_stereo_core_sequencer;

  localparam int SKEW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] left_in_data, right_in_data, core_in_data, core_out_data;
  logic        left_in_valid, left_in_ready, right_in_valid, right_in_ready;
  logic        core_in_chan, core_in_valid, core_in_ready, core_out_valid, core_out_ready;
  logic [23:0] left_out_data, right_out_data;
  logic        left_out_valid, left_out_ready, right_out_valid, right_out_ready;
  logic [24:0] damping_in, decay_in, damping_q, decay_q;
  logic [23:0] mix_in, mix_q;
  logic [9:0]  predelay_in, predelay_q;
  logic [15:0] frame_count;
  logic        pair_error;
  logic [2:0]  state_dbg;

  stereo_core_sequencer #(.SKEW_MAX(SKEW)) dut (
    .clk(clk), .reset(reset),
    .left_in_data(left_in_data), .left_in_valid(left_in_valid), .left_in_ready(left_in_ready),
    .right_in_data(right_in_data), .right_in_valid(right_in_valid), .right_in_ready(right_in_ready),
    .core_in_data(core_in_data), .core_in_chan(core_in_chan), .core_in_valid(core_in_valid),
    .core_in_ready(core_in_ready), .core_out_data(core_out_data), .core_out_valid(core_out_valid),
    .core_out_ready(core_out_ready),
    .left_out_data(left_out_data), .left_out_valid(left_out_valid), .left_out_ready(left_out_ready),
    .right_out_data(right_out_data), .right_out_valid(right_out_valid), .right_out_ready(right_out_ready),
    .damping_in(damping_in), .decay_in(decay_in), .mix_in(mix_in), .predelay_in(predelay_in),
    .damping_q(damping_q), .decay_q(decay_q), .mix_q(mix_q), .predelay_q(predelay_q),
    .frame_count(frame_count), .pair_error(pair_error), .state_dbg(state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  logic [24:0] exp_q[$];
  logic [15:0] exp_fc;
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned t0;

  typedef struct {
    logic [23:0] l, r;
    int          lat;
    logic [24:0] damp, decay;
    logic [23:0] mix;
    logic [9:0]  pdly;
    logic [23:0] exp_l, exp_r;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver tasks: all are entered and left on a negedge.
  task automatic present_pair(input logic [23:0] l, input logic [23:0] r);
    chk("left_in_ready_idle", left_in_ready, 1);
    chk("right_in_ready_idle", right_in_ready, 1);
    left_in_valid = 1; left_in_data = l;
    right_in_valid = 1; right_in_data = r;
    exp_q.push_back({1'b0, l});
    exp_q.push_back({1'b1, r});
    t0 = cyc;
    @(negedge clk);
    left_in_valid = 0; right_in_valid = 0;
  endtask

  task automatic serve(input int lat, input int hold, input bit chg, input logic [24:0] new_damp);
    int t;
    logic [24:0] e;
    t = 0;
    if (hold > 0) core_in_ready = 0;
    while (!core_in_valid && t < 100) begin
      @(negedge clk); t++;
    end
    chk("core_in_valid_seen", core_in_valid, 1);
    e = exp_q.pop_front();
    chk("core_in_data", core_in_data, e[23:0]);
    chk("core_in_chan", core_in_chan, e[24]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("in_ready_busy", {left_in_ready, right_in_ready}, 0);
      chk("core_in_valid_held", core_in_valid, 1);
    end
    core_in_ready = 1;
    @(negedge clk);
    chk("core_out_ready", core_out_ready, 1);
    if (chg) damping_in = new_damp;
    repeat (lat - 1) @(negedge clk);
    core_out_valid = 1;
    core_out_data  = e[23:0] ^ 24'hFFFFFF;
    @(negedge clk);
    core_out_valid = 0;
  endtask

  task automatic collect(input logic [23:0] el, input logic [23:0] er, input int ld, input int rd,
                         input bit min_lat);
    int t, k;
    bit dl, dr;
    t = 0;
    while (!left_out_valid && t < 100) begin
      @(negedge clk); t++;
    end
    chk("left_out_valid_seen", left_out_valid, 1);
    chk("right_out_valid_together", right_out_valid, 1);
    if (min_lat) chk("min_frame_latency", cyc - t0, 5);
    chk("left_out_data", left_out_data, el);
    chk("right_out_data", right_out_data, er);
    chk("in_ready_output", {left_in_ready, right_in_ready}, 0);
    k = 0; dl = 0; dr = 0;
    while (!(dl && dr) && k < 60) begin
      left_out_ready  = (k >= ld);
      right_out_ready = (k >= rd);
      chk("left_out_valid", left_out_valid, !dl);
      chk("right_out_valid", right_out_valid, !dr);
      chk("frame_count_hold", frame_count, exp_fc);
      if (left_out_valid && left_out_ready) dl = 1;
      if (right_out_valid && right_out_ready) dr = 1;
      @(negedge clk);
      k++;
    end
    left_out_ready = 0; right_out_ready = 0;
    chk("output_handshakes_done", {dl, dr}, 2'b11);
    exp_fc = exp_fc + 16'd1;
    chk("frame_count", frame_count, exp_fc);
    chk("state_capture", state_dbg, 0);
  endtask

  task automatic run_vec(input vec_t v);
    damping_in = v.damp; decay_in = v.decay; mix_in = v.mix; predelay_in = v.pdly;
    present_pair(v.l, v.r);
    serve(v.lat, 0, 0, '0);
    serve(v.lat, 0, 0, '0);
    collect(v.exp_l, v.exp_r, 0, 0, v.lat == 1);
    chk("damping_q", damping_q, v.damp);
    chk("decay_q", decay_q, v.decay);
    chk("mix_q", mix_q, v.mix);
    chk("predelay_q", predelay_q, v.pdly);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_in_ready"}, {left_in_ready, right_in_ready}, 0);
    chk({tag, "_core_in"}, {core_in_valid, core_in_chan, core_out_ready}, 0);
    chk({tag, "_core_in_data"}, core_in_data, 0);
    chk({tag, "_out_valid"}, {left_out_valid, right_out_valid}, 0);
    chk({tag, "_out_data"}, left_out_data | right_out_data, 0);
    chk({tag, "_params"}, damping_q | decay_q | 25'(mix_q) | 25'(predelay_q), 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_pair_error"}, pair_error, 0);
    chk({tag, "_state"}, state_dbg, 0);
  endtask

  initial begin
    vecs[0] = '{24'h123456, 24'hABCDEF, 3, 25'h0000100, 25'h1ABCDEF, 24'h400000, 10'h3FF, 24'hEDCBA9, 24'h543210};
    vecs[1] = '{24'h000000, 24'hFFFFFF, 1, 25'h1FFFFFF, 25'h0000001, 24'hFFFFFF, 10'h000, 24'hFFFFFF, 24'h000000};
    vecs[2] = '{24'h800000, 24'h7FFFFF, 2, 25'h1000000, 25'h0FFFFFF, 24'h000001, 10'h200, 24'h7FFFFF, 24'h800000};
    vecs[3] = '{24'hA5A5A5, 24'h5A5A5A, 4, 25'h0123456, 25'h1654321, 24'hC0FFEE, 10'h155, 24'h5A5A5A, 24'hA5A5A5};

    reset = 1;
    left_in_valid = 0; right_in_valid = 0; left_in_data = 0; right_in_data = 0;
    core_in_ready = 1; core_out_valid = 0; core_out_data = 0;
    left_out_ready = 0; right_out_ready = 0;
    damping_in = 0; decay_in = 0; mix_in = 0; predelay_in = 0;
    exp_fc = 0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    reset = 0;
    @(negedge clk);
    chk("in_ready_after_reset", {left_in_ready, right_in_ready}, 2'b11);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Parameter freeze: damping_in changes while the left sample is at the core.
    damping_in = 25'h000100;
    present_pair(24'h010203, 24'h040506);
    serve(3, 0, 1, 25'h000200);
    chk("damping_q_frozen_mid", damping_q, 25'h000100);
    serve(3, 0, 0, '0);
    collect(24'hFEFDFC, 24'hFBFAF9, 0, 0, 0);
    chk("damping_q_frozen_end", damping_q, 25'h000100);
    present_pair(24'h000001, 24'h000002);
    chk("damping_q_next_frame", damping_q, 25'h000200);
    serve(1, 0, 0, '0);
    serve(1, 0, 0, '0);
    collect(24'hFFFFFE, 24'hFFFFFD, 0, 0, 1);

    // Skew timeout: left alone is dropped SKEW edges after acceptance.
    left_in_valid = 1; left_in_data = 24'h111111;
    @(negedge clk);
    left_in_valid = 0;
    for (int i = 1; i <= 10; i++) begin
      chk("skew_pair_error", pair_error, i == 9);
      chk("skew_left_in_ready", left_in_ready, i >= 9);
      chk("skew_no_core_traffic", core_in_valid, 0);
      @(negedge clk);
    end
    chk("skew_frame_count", frame_count, exp_fc);

    // Partner arrives on the very cycle the lone sample would time out.
    left_in_valid = 1; left_in_data = 24'h222222;
    @(negedge clk);
    left_in_valid = 0;
    repeat (7) @(negedge clk);
    right_in_valid = 1; right_in_data = 24'h333333;
    exp_q.push_back({1'b0, 24'h222222});
    exp_q.push_back({1'b1, 24'h333333});
    @(negedge clk);
    right_in_valid = 0;
    chk("rescue_no_pair_error", pair_error, 0);
    chk("rescue_state_send_l", state_dbg, 1);
    serve(2, 0, 0, '0);
    serve(2, 0, 0, '0);
    collect(24'hDDDDDD, 24'hCCCCCC, 0, 0, 0);

    // Back-pressure: core stalls 20 cycles, right sink stalls 5 cycles after left completes.
    present_pair(24'h0F0F0F, 24'hF0F0F0);
    serve(2, 20, 0, '0);
    serve(2, 0, 0, '0);
    collect(24'hF0F0F0, 24'h0F0F0F, 0, 6, 0);

    // Reset while waiting for the right result.
    present_pair(24'h777777, 24'h888888);
    serve(1, 0, 0, '0);
    chk("mid_core_in_chan", core_in_chan, 1);
    @(negedge clk);
    chk("mid_state_recv_r", state_dbg, 4);
    reset = 1;
    @(negedge clk);
    chk_outputs_zero("mid_reset");
    reset = 0;
    exp_q.delete();
    exp_fc = 0;
    @(negedge clk);
    chk("mid_reset_no_pair_error", pair_error, 0);
    run_vec(vecs[0]);

    // Frame counter wrap.
    force dut.frame_count = 16'hFFFF;
    #1;
    release dut.frame_count;
    exp_fc = 16'hFFFF;
    @(negedge clk);
    run_vec(vecs[3]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stereo_core_sequencer.md
# stereo_core_sequencer

Sequences one shared mono reverb core across both audio channels. It takes left and right 24-bit samples from the audio controller's Avalon-ST source ports, pairs them into a frame, and sends them to the core one at a time: left, then right. It collects the core results and presents them as a stereo pair to the audio controller's sink ports. It also freezes the damping, decay, mix and predelay PIO values at each frame start, so the core never sees a parameter change in the middle of a frame.

## Interface
- DATA_W, 24, sample width
- DAMP_W, 25, damping value width
- DECAY_W, 25, decay value width
- MIX_W, 24, mix value width
- PDLY_W, 10, predelay value width
- SKEW_MAX, 1023, maximum wait in cycles for the second channel of a pair (≥1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- left_in_data / right_in_data  in  DATA_W  samples from the audio controller source
- left_in_valid / right_in_valid  in  1  source valid
- left_in_ready / right_in_ready  out  1  source ready
- core_in_data  out  DATA_W  sample sent to the core
- core_in_chan  out  1  channel tag: 0 = left, 1 = right
- core_in_valid  out  1
- core_in_ready  in  1
- core_out_data  in  DATA_W  core result
- core_out_valid  in  1
- core_out_ready  out  1
- left_out_data / right_out_data  out  DATA_W  results to the audio controller sink
- left_out_valid / right_out_valid  out  1
- left_out_ready / right_out_ready  in  1
- damping_in, decay_in, mix_in, predelay_in  in  DAMP_W / DECAY_W / MIX_W / PDLY_W  live PIO values
- damping_q, decay_q, mix_q, predelay_q  out  same widths  per-frame frozen parameters
- frame_count  out  16  completed frames, wraps 0xFFFF→0
- pair_error  out  1  one-cycle pulse when a lone sample is dropped

## Operation
- FSM states: CAPTURE, SEND_L, RECV_L, SEND_R, RECV_R, OUTPUT.
- CAPTURE
  - Each channel has a hold register and a held flag.
  - x_in_ready = !held_x. Each channel is accepted independently. Both can be accepted in the same cycle.
  - Once both flags are set (including the cycle they become set together), the next state is SEND_L.
  - On that transition, all four *_q outputs load from *_in.
- Skew counter
  - Runs while exactly one channel is held; cleared otherwise.
  - When it reaches SKEW_MAX, the lone held sample is discarded and pair_error pulses for one cycle.
  - If the missing channel is accepted in that same cycle, it is paired normally and nothing is dropped.
- SEND_L: core_in_valid=1, core_in_chan=0, core_in_data=left hold. On core_in_ready → RECV_L.
- RECV_L: core_out_ready=1. On core_out_valid, store the left result → SEND_R.
- SEND_R / RECV_R: the same, with chan=1 and the right hold. On the core result → OUTPUT, and both held flags clear.
- OUTPUT
  - left_out_valid and right_out_valid rise together.
  - Each drops after its own handshake; handshakes may land in different cycles.
  - When both are done (same cycle or later) → CAPTURE and frame_count+1.
- In-ready while busy: x_in_ready stays 0 in every state except CAPTURE, so the audio controller FIFOs provide the back-pressure.
- core_out_valid outside RECV_x: ignored. core_out_ready=0.
- *_in changes outside the CAPTURE→SEND_L edge: no effect on *_q.
- Data widths: samples pass through unmodified; no arithmetic is done on them.

## Timing
- Reset values:
  - State: CAPTURE.
  - Cleared to 0: all ready/valid outputs, core_in_chan, *_q, frame_count, pair_error, data outputs, hold registers, skew counter.
- x_in_ready is registered-state decode: it is 1 in the first cycle after reset deassertion.
- Core handshake outputs are pure state decode; nothing is combinational from the core inputs.
- Minimum frame (core ready immediately, result the next cycle, sinks ready): 6 cycles from pair capture to the output handshake. Breakdown: capture, SEND_L, RECV_L, SEND_R, RECV_R, OUTPUT.
- Reset mid-frame:
  - Abort next cycle and drop held samples and results.
  - No pair_error; frame_count returns to 0.

## Test plan
- Basic pair:
  - Stimulus: left=0x123456 and right=0xABCDEF in the same cycle; the core returns input XOR 0xFFFFFF after 3 cycles.
  - Required: left_out=0xEDCBA9 and right_out=0x543210, both valid together; frame_count=1; core_in_chan sequence 0 then 1.
- Parameter freeze:
  - Stimulus: damping_in changes 0x000100→0x000200 while in RECV_L.
  - Required: damping_q stays 0x000100 for that frame and shows 0x000200 only after the next capture.
- Skew timeout:
  - Stimulus: SKEW_MAX=8; left only is presented.
  - Required: pair_error pulses once, 8 cycles after acceptance; no core traffic; left_in_ready returns to 1.
- Back-pressure:
  - Stimulus: core_in_ready=0 for 20 cycles, then right_out_ready held 0 for 5 cycles after left_out completes.
  - Required: no data loss; x_in_ready=0 throughout; the frame completes only after the right handshake.
- Reset mid-frame:
  - Stimulus: assert reset in RECV_R.
  - Required: next cycle all outputs are 0 and state is CAPTURE; a subsequent pair processes correctly with frame_count=1.
- Wrap:
  - Stimulus: preload or run 65536 frames.
  - Required: frame_count goes 0xFFFF→0x0000.
